// File: rtl/count_monitor.sv
// count_monitor: watches an upstream free-running up-counter, pulses and
// counts every all-ones -> zero wrap, and captures a one-shot snapshot of
// {wrap count, counter value} when the counter hits an armed compare value.
// The snapshot is offered through a valid/ready handshake.
module count_monitor #(
  parameter int CW = 4,
  parameter int WW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CW-1:0]    count_in,
  input  logic             arm,
  input  logic [CW-1:0]    match_val,
  output logic             wrap_pulse,
  output logic [WW-1:0]    wrap_cnt,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WW+CW-1:0] evt_data,
  output logic [1:0]       state
);

  // Debug-visible state encoding; 2'd3 is unused and falls back to IDLE.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [CW-1:0]    r_prev_q;
  logic             r_prev_ok;
  logic             r_wrap_pulse;
  logic [WW-1:0]    r_wrap_cnt;
  logic [CW-1:0]    r_match_q;
  logic [WW+CW-1:0] r_evt_data;

  logic w_wrap;
  logic w_match;
  logic w_load_evt;
  logic w_capture_match;

  // A wrap needs a trusted previous sample: the first edge after reset
  // never qualifies, and jumps or holds at all-ones are not wraps.
  assign w_wrap  = r_prev_ok && (r_prev_q == '1) && (count_in == '0);
  assign w_match = (count_in == r_match_q);

  // A match in ARMED takes priority over a simultaneous re-arm.
  assign w_load_evt      = (r_state == S_ARMED) && w_match;
  assign w_capture_match = ((r_state == S_IDLE)  && arm) ||
                           ((r_state == S_ARMED) && arm && !w_match);

  // Wrap detection and saturating wrap counter, independent of the FSM.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_prev_q     <= '0;
      r_prev_ok    <= 1'b0;
      r_wrap_pulse <= 1'b0;
      r_wrap_cnt   <= '0;
    end else begin
      r_prev_q     <= count_in;
      r_prev_ok    <= 1'b1;
      r_wrap_pulse <= w_wrap;
      if (w_wrap && (r_wrap_cnt != '1)) begin
        r_wrap_cnt <= r_wrap_cnt + WW'(1);
      end
    end
  end

  // Compare-value and snapshot capture; evt_data holds until re-loaded.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_match_q  <= '0;
      r_evt_data <= '0;
    end else begin
      if (w_capture_match) begin
        r_match_q <= match_val;
      end
      if (w_load_evt) begin
        r_evt_data <= {r_wrap_cnt, count_in};
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic; arm is ignored in HOLD, evt_ready outside HOLD.
  // NOTE: the default assignment first keeps this purely combinational,
  // so no latch is inferred on paths that do not assign.
  always_comb begin
    w_next_state = S_IDLE;
    case (r_state)
      S_IDLE:  w_next_state = arm       ? S_ARMED : S_IDLE;
      S_ARMED: w_next_state = w_match   ? S_HOLD  : S_ARMED;
      S_HOLD:  w_next_state = evt_ready ? S_IDLE  : S_HOLD;
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM outputs: an event is pending exactly while in HOLD.
  always_comb begin
    evt_valid = (r_state == S_HOLD);
    state     = r_state;
  end

  assign wrap_pulse = r_wrap_pulse;
  assign wrap_cnt   = r_wrap_cnt;
  assign evt_data   = r_evt_data;

endmodule

// File: tb/tb_count_monitor.sv
// Bench for count_monitor: a behavioural model (unbounded wrap tally,
// saturated only at the output) is checked against the DUT every cycle,
// and directed scenarios carry hand-computed literal expectations.
module tb_count_monitor;

  localparam int CW   = 4;
  localparam int WW   = 8;
  localparam int MAXC = (1 << CW) - 1;
  localparam int MAXW = (1 << WW) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [CW-1:0]    count_in;
  logic             arm;
  logic [CW-1:0]    match_val;
  logic             wrap_pulse;
  logic [WW-1:0]    wrap_cnt;
  logic             evt_valid;
  logic             evt_ready;
  logic [WW+CW-1:0] evt_data;
  logic [1:0]       state;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;
  int cnt      = 0;

  count_monitor #(.CW(CW), .WW(WW)) dut (
    .clk(clk), .rst(rst), .count_in(count_in), .arm(arm),
    .match_val(match_val), .wrap_pulse(wrap_pulse), .wrap_cnt(wrap_cnt),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_prev;
  bit m_have_prev;
  int m_wraps;     // unbounded wrap tally
  bit m_pulse;
  int m_state;     // 0 idle, 1 armed, 2 holding an event
  int m_target;
  bit m_valid;
  int m_data;

  function automatic int sat_wraps(input int w);
    return (w > MAXW) ? MAXW : w;
  endfunction

  always @(posedge clk) begin
    bit wrap;
    if (!rst) begin
      m_prev = 0; m_have_prev = 0; m_wraps = 0; m_pulse = 0;
      m_state = 0; m_target = 0; m_valid = 0; m_data = 0;
    end else begin
      wrap = m_have_prev && (m_prev == MAXC) && (int'(count_in) == 0);
      case (m_state)
        0: if (arm) begin
             m_target = int'(match_val);
             m_state  = 1;
           end
        1: if (int'(count_in) == m_target) begin
             m_data  = sat_wraps(m_wraps) * (MAXC + 1) + int'(count_in);
             m_valid = 1;
             m_state = 2;
           end else if (arm) begin
             m_target = int'(match_val);
           end
        default: if (evt_ready) begin
             m_valid = 0;
             m_state = 0;
           end
      endcase
      if (wrap) m_wraps++;
      m_pulse     = wrap;
      m_prev      = int'(count_in);
      m_have_prev = 1;
    end
  end

  // Compare process: outputs are checked against the model every cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_wrap_pulse", 32'(wrap_pulse), 32'(m_pulse));
      check("m_wrap_cnt",   32'(wrap_cnt),   32'(sat_wraps(m_wraps)));
      check("m_evt_valid",  32'(evt_valid),  32'(m_valid));
      check("m_state",      32'(state),      32'(m_state));
      if (m_valid) check("m_evt_data", 32'(evt_data), 32'(m_data));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic put(input int v);
    cnt      = v;
    count_in = CW'(v);
    cyc();
  endtask

  task automatic adv();
    put((cnt + 1) % (MAXC + 1));
  endtask

  task automatic wait_evt(input string name);
    int n;
    n = 0;
    while (!evt_valid && n < 20) begin
      adv();
      n++;
    end
    if (!evt_valid) check({name, "_timeout"}, 32'(evt_valid), 32'(1));
  endtask

  initial begin
    int pulses;
    int late_pulses;

    rst = 1'b0; count_in = CW'(MAXC); arm = 1'b0;
    match_val = '0; evt_ready = 1'b0;

    // Reset held three edges while count_in toggles 15/0.
    cyc();
    cmp_en = 1'b1;
    check("rst_wrap_cnt", 32'(wrap_cnt), 32'(0));
    count_in = '0;     cyc();
    count_in = CW'(MAXC); cyc();
    check("rst_pulse",     32'(wrap_pulse), 32'(0));
    check("rst_evt_valid", 32'(evt_valid),  32'(0));
    check("rst_evt_data",  32'(evt_data),   32'(0));
    check("rst_state",     32'(state),      32'(0));
    rst = 1'b1;
    put(0);
    check("first_edge_pulse", 32'(wrap_pulse), 32'(0));

    // One wrap so that wrap_cnt = 1.
    repeat (16) adv();
    check("wrap1_pulse", 32'(wrap_pulse), 32'(1));
    check("wrap1_cnt",   32'(wrap_cnt),   32'(1));

    // Arm for 9 and let the counter run into it.
    arm = 1'b1; match_val = CW'(9);
    adv();
    check("armed_state", 32'(state), 32'(1));
    arm = 1'b0; match_val = '0;
    wait_evt("evt9");
    check("evt9_cnt",   32'(cnt),      32'(9));
    check("evt9_data",  32'(evt_data), 32'('h019));
    check("evt9_state", 32'(state),    32'(2));
    repeat (5) begin
      adv();
      check("evt9_hold_data",  32'(evt_data),  32'('h019));
      check("evt9_hold_valid", 32'(evt_valid), 32'(1));
    end
    evt_ready = 1'b1;
    adv();
    check("evt9_accept_valid", 32'(evt_valid), 32'(0));
    check("evt9_accept_state", 32'(state),     32'(0));
    evt_ready = 1'b0;

    // Match wins over a simultaneous re-arm.
    arm = 1'b1; match_val = CW'(4);
    adv();                     // count 0: wrap 2, enter ARMED
    arm = 1'b0;
    repeat (3) adv();          // 1,2,3
    arm = 1'b1; match_val = CW'(7);
    adv();                     // count 4
    check("race_valid", 32'(evt_valid), 32'(1));
    check("race_data",  32'(evt_data),  32'('h024));

    // arm during HOLD and on the accepting edge is ignored.
    match_val = CW'(2);
    repeat (3) begin
      adv();
      check("hold_arm_state", 32'(state),    32'(2));
      check("hold_arm_data",  32'(evt_data), 32'('h024));
    end
    evt_ready = 1'b1;
    adv();
    check("accept_arm_state", 32'(state), 32'(0));
    evt_ready = 1'b0; arm = 1'b0;
    adv();
    check("idle_after_accept", 32'(state), 32'(0));

    // Changing match_val after arming has no effect.
    arm = 1'b1; match_val = CW'(6);
    adv();
    arm = 1'b0; match_val = CW'(11);
    wait_evt("evt6");
    check("evt6_cnt",  32'(cnt),      32'(6));
    check("evt6_data", 32'(evt_data), 32'('h036));

    // Reset in HOLD discards the event.
    rst = 1'b0;
    adv();
    check("hold_rst_valid", 32'(evt_valid), 32'(0));
    check("hold_rst_wraps", 32'(wrap_cnt),  32'(0));
    check("hold_rst_state", 32'(state),     32'(0));
    rst = 1'b1; evt_ready = 1'b1;
    repeat (3) adv();
    check("late_ready_valid", 32'(evt_valid), 32'(0));
    check("late_ready_state", 32'(state),     32'(0));
    evt_ready = 1'b0;

    // 0..15 twice then 0: exactly two pulses.
    pulses = 0;
    for (int p = 0; p < 2; p++) begin
      for (int v = 0; v <= MAXC; v++) begin
        put(v);
        if (wrap_pulse) pulses++;
      end
    end
    put(0);
    if (wrap_pulse) pulses++;
    check("two_pass_pulses", 32'(pulses),   32'(2));
    check("two_pass_cnt",    32'(wrap_cnt), 32'(2));

    // Jump from 15 and a hold at 15 are not wraps.
    pulses = 0;
    put(MAXC); if (wrap_pulse) pulses++;
    put(3);    if (wrap_pulse) pulses++;
    put(MAXC); if (wrap_pulse) pulses++;
    put(MAXC); if (wrap_pulse) pulses++;
    put(1);    if (wrap_pulse) pulses++;
    check("nonwrap_pulses", 32'(pulses),   32'(0));
    check("nonwrap_cnt",    32'(wrap_cnt), 32'(2));

    // 300 wraps: counter saturates, pulses keep firing.
    pulses = 0; late_pulses = 0;
    repeat (300 * (MAXC + 1)) begin
      adv();
      if (wrap_pulse) begin
        pulses++;
        if (wrap_cnt == WW'(MAXW)) late_pulses++;
      end
    end
    check("sat_pulses",      32'(pulses),      32'(300));
    check("sat_late_pulses", 32'(late_pulses), 32'(48));
    check("sat_cnt",         32'(wrap_cnt),    32'(255));

    cyc();
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/count_monitor.md
COUNT_MONITOR -- requirements
Module: count_monitor

Interface
REQ-001 Parameter CW, default 4, width of the upstream counter value.
REQ-002 Parameter WW, default 8, width of the wrap counter.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-low reset; sampled only on posedge clk.
REQ-005 count_in  input  CW  upstream free-running up-counter value, sampled every clk edge.
REQ-006 arm  input  1  request to arm the match trigger; level sampled each edge.
REQ-007 match_val  input  CW  compare value, captured on a valid arm.
REQ-008 wrap_pulse  output  1  one-cycle pulse per detected count wrap.
REQ-009 wrap_cnt  output  WW  number of wraps since reset, saturating.
REQ-010 evt_valid  output  1  captured event is available.
REQ-011 evt_ready  input  1  consumer accepts the event.
REQ-012 evt_data  output  WW+CW  captured snapshot {wrap_cnt, count_in}.
REQ-013 state  output  2  FSM state for debug: IDLE=0, ARMED=1, HOLD=2; encoding 3 is unused.

Function
REQ-014 The block SHALL register count_in into prev_q on every edge, with a prev_ok flag set on the first edge after reset release.
REQ-015 A wrap SHALL be detected at an edge when prev_ok=1, prev_q equals all ones and count_in equals 0; no other transition is a wrap, including count_in jumps or holds.
REQ-016 wrap_pulse SHALL be registered: high for exactly the cycle following the detecting edge, low otherwise.
REQ-017 wrap_cnt SHALL increment by 1 on each detecting edge and hold at 2^WW-1; the saturation limit SHALL NOT suppress wrap_pulse.
REQ-018 In IDLE with arm=1, the block SHALL capture match_val into match_q and enter ARMED; no compare SHALL occur on that edge.
REQ-019 In ARMED, when count_in equals match_q at an edge, the block SHALL load evt_data={wrap_cnt value before that edge's update, count_in}, set evt_valid and enter HOLD.
REQ-020 In ARMED with arm=1 and no match, the block SHALL recapture match_val and remain in ARMED.
REQ-021 In ARMED with a match and arm=1 on the same edge, the match SHALL win: the event is captured against the old match_q and arm is ignored.
REQ-022 In HOLD, evt_valid SHALL stay high and evt_data SHALL stay stable until an edge with evt_ready=1.
REQ-023 On an edge in HOLD with evt_ready=1, evt_valid SHALL clear and the FSM SHALL enter IDLE.
REQ-024 arm SHALL be ignored in HOLD and on the accepting edge; re-arming requires a later edge in IDLE.
REQ-025 evt_ready SHALL be ignored outside HOLD.
REQ-026 Wrap detection and wrap_cnt SHALL operate independently of the FSM state.
REQ-027 An unused state encoding SHALL return to IDLE on the next edge, with evt_valid cleared.

Reset
REQ-028 On an edge with rst=0, the block SHALL set the following, overriding all other inputs:
- wrap_pulse=0, wrap_cnt=0, evt_valid=0, evt_data=0;
- match_q=0, prev_q=0, prev_ok=0;
- state=IDLE.
REQ-029 A reset in any state, including HOLD, SHALL discard the pending event without a handshake.
REQ-030 The first edge after reset release SHALL NOT detect a wrap, whatever count_in is.

Verification
REQ-031 Hold rst=0 for 3 cycles with count_in toggling 15/0, then release with count_in=0 -> all outputs 0 throughout, no wrap_pulse on the first post-release edge.
REQ-032 Drive count_in 0..15 twice, then 0 -> exactly 2 single-cycle wrap_pulse highs, each one cycle after the 15->0 edge, final wrap_cnt=2; count_in 15->3 and a hold at 15 -> no pulse.
REQ-033 Drive 300 full wraps -> wrap_cnt reaches 255 and holds, wrap_pulse still fires on wraps 256-300.
REQ-034 With wrap_cnt=1, pulse arm with match_val=9, run the counter -> evt_valid rises the cycle after count_in=9 is sampled, evt_data=0x019, state=HOLD; hold evt_ready=0 for 5 cycles -> evt_data unchanged; evt_ready=1 -> evt_valid=0 and state=IDLE next cycle.
REQ-035 Three cases:
- In ARMED with match_q=4, assert arm with match_val=7 on the edge where count_in=4 -> event captured at count 4, match_q stays 4.
- arm during HOLD -> ignored.
- arm in IDLE then match_val changed -> the new value is unused until re-arm.
REQ-036 In HOLD with evt_valid=1, assert rst=0 for one edge -> evt_valid=0, wrap_cnt=0, state=IDLE; a later evt_ready=1 has no effect.
